// File: rtl/mult_dispatch_pkg.sv
// Shared types and helpers for the RV32M multiply dispatcher and its optional result cache.
package mult_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic        vld;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] funct;
        logic [31:0] data;
    } cache_entry_t;

    // MULT decodes its operation from this packed selection of instruction bits
    function automatic logic [11:0] mk_funct12(input logic [31:0] inst);
        return {inst[30], inst[25], inst[14:12], inst[6:0]};
    endfunction

endpackage

// File: rtl/mult_dispatch_cache.sv
// One-entry last-result cache for mult_dispatch (only built when MULT_CACHE_EN is defined).
// Combinational lookup; fill and clear take effect on the next rising edge.
module mult_dispatch_cache
    import mult_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fill,
    input  logic        i_clear,
    input  logic [31:0] i_fill_rs1,
    input  logic [31:0] i_fill_rs2,
    input  logic [11:0] i_fill_funct,
    input  logic [31:0] i_fill_data,
    input  logic [31:0] i_lk_rs1,
    input  logic [31:0] i_lk_rs2,
    input  logic [11:0] i_lk_funct,
    output logic        o_hit,
    output logic [31:0] o_data
);

    cache_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_entry <= '0;
        end else if (i_fill) begin
            r_entry <= '{vld: 1'b1, rs1: i_fill_rs1, rs2: i_fill_rs2,
                         funct: i_fill_funct, data: i_fill_data};
        end
    end

    assign o_hit  = r_entry.vld && (r_entry.rs1 == i_lk_rs1) &&
                    (r_entry.rs2 == i_lk_rs2) && (r_entry.funct == i_lk_funct);
    assign o_data = r_entry.data;

endmodule

// File: rtl/mult_dispatch.sv
// Issue stage in front of the MULT unit: one RV32M multiply in flight, result returned over valid/ready.
// Optional one-entry result cache under MULT_CACHE_EN; in_ready is high only in IDLE.
module mult_dispatch
    import mult_dispatch_pkg::*;
#(
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        mult_enable,
    output logic [11:0] mult_funct3,
    output logic [31:0] mult_rs1,
    output logic [31:0] mult_rs2,
    input  logic [31:0] mult_rd,
    input  logic        mult_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_data,
    output logic        out_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t       r_state;
    logic [TW-1:0] r_tmo;
    logic [GW-1:0] r_gap;
    logic         r_mult_enable;
    logic [11:0]  r_mult_funct3;
    logic [31:0]  r_mult_rs1;
    logic [31:0]  r_mult_rs2;
    logic         r_out_valid;
    logic [4:0]   r_out_rd_addr;
    logic [31:0]  r_out_data;
    logic         r_out_err;

    logic         w_legal;
    logic [11:0]  w_funct12;
    logic         w_tmo_hit;
    logic         w_gap_done;
    logic         w_hit;
    logic [31:0]  w_cache_data;
    logic         w_unused;

    assign w_legal    = (in_inst[6:0] == OPC_OP) && (in_inst[31:25] == F7_MULDIV) && !in_inst[14];
    assign w_funct12  = mk_funct12(in_inst);
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_gap_done = (r_gap >= GW'(GAP_CYCLES));
    assign w_unused   = &{1'b0, in_inst[24:15]};

`ifdef MULT_CACHE_EN
    logic w_fill;
    logic w_clear;

    assign w_fill  = (r_state == ST_BUSY) && mult_done;
    assign w_clear = (r_state == ST_BUSY) && !mult_done && w_tmo_hit;

    mult_dispatch_cache u_cache (
        .clk          (clk),
        .reset        (reset),
        .i_fill       (w_fill),
        .i_clear      (w_clear),
        .i_fill_rs1   (r_mult_rs1),
        .i_fill_rs2   (r_mult_rs2),
        .i_fill_funct (r_mult_funct3),
        .i_fill_data  (mult_rd),
        .i_lk_rs1     (in_rs1),
        .i_lk_rs2     (in_rs2),
        .i_lk_funct   (w_funct12),
        .o_hit        (w_hit),
        .o_data       (w_cache_data)
    );
`else
    assign w_hit        = 1'b0;
    assign w_cache_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_mult_enable <= 1'b0;
            r_mult_funct3 <= '0;
            r_mult_rs1    <= '0;
            r_mult_rs2    <= '0;
            r_out_valid   <= 1'b0;
            r_out_rd_addr <= '0;
            r_out_data    <= '0;
            r_out_err     <= 1'b0;
        end else begin
            // Gap counts every cycle Enable is low; restarted when a new op issues
            if (!r_mult_enable && !w_gap_done) r_gap <= r_gap + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_out_rd_addr <= in_inst[11:7];
                        if (!w_legal) begin
                            r_out_err   <= 1'b1;
                            r_out_data  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (w_hit) begin
                            r_out_err   <= 1'b0;
                            r_out_data  <= w_cache_data;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mult_funct3 <= w_funct12;
                            r_mult_rs1    <= in_rs1;
                            r_mult_rs2    <= in_rs2;
                            r_mult_enable <= 1'b1;
                            r_tmo         <= '0;
                            r_gap         <= '0;
                            r_state       <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mult_done) begin
                        r_mult_enable <= 1'b0;
                        r_out_data    <= mult_rd;
                        r_out_err     <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (w_tmo_hit) begin
                        r_mult_enable <= 1'b0;
                        r_out_data    <= '0;
                        r_out_err     <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_gap_done && !mult_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign mult_enable = r_mult_enable;
    assign mult_funct3 = r_mult_funct3;
    assign mult_rs1    = r_mult_rs1;
    assign mult_rs2    = r_mult_rs2;
    assign out_valid   = r_out_valid;
    assign out_rd_addr = r_out_rd_addr;
    assign out_data    = r_out_data;
    assign out_err     = r_out_err;

endmodule

// File: tb/tb_mult_dispatch.sv
// Bench for mult_dispatch: behavioural MULT model with programmable latency or hang, table vectors,
// multi-cycle corner sequences and randomized ops; builds with or without MULT_CACHE_EN.
module tb_mult_dispatch;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        mult_enable;
    logic [11:0] mult_funct3;
    logic [31:0] mult_rs1;
    logic [31:0] mult_rs2;
    logic [31:0] mult_rd = 32'h0;
    logic        mult_done = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_data;
    logic        out_err;

    int errs   = 0;
    int checks = 0;
    int stub_lat  = 2;
    bit stub_hang = 1'b0;
    int stub_cnt  = 0;

    always #5 clk = ~clk;

    mult_dispatch #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .mult_enable(mult_enable), .mult_funct3(mult_funct3),
        .mult_rs1(mult_rs1), .mult_rs2(mult_rs2),
        .mult_rd(mult_rd), .mult_done(mult_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_addr(out_rd_addr), .out_data(out_data), .out_err(out_err)
    );

    // RV32M multiply semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_mult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'h0, a};
        longint ub = {32'h0, b};
        logic [63:0] p;
        case (f)
            2'd0:    begin p = ua * ub; return p[31:0];  end
            2'd1:    begin p = sa * sb; return p[63:32]; end
            2'd2:    begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // MULT model: Done rises stub_lat+1 edges after Enable, held until Enable falls
    always @(posedge clk) begin
        if (reset || !mult_enable || stub_hang) begin
            stub_cnt  <= 0;
            mult_done <= 1'b0;
        end else begin
            if (stub_cnt == stub_lat) begin
                mult_done <= 1'b1;
                mult_rd   <= ref_mult(mult_funct3[8:7], mult_rs1, mult_rs2);
            end
            stub_cnt <= stub_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit en_seen, output bit en_at_v,
                        output logic [11:0] f12, output logic [31:0] o1, output logic [31:0] o2,
                        output bit en1);
        wait_idle();
        in_valid = 1'b1; in_inst = inst; in_rs1 = a; in_rs2 = b;
        @(negedge clk);
        in_valid = 1'b0; in_inst = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
        en1 = mult_enable; f12 = mult_funct3; o1 = mult_rs1; o2 = mult_rs2;
        lat = 1; en_seen = 1'b0;
        while (!out_valid && lat < 300) begin
            en_seen |= mult_enable;
            @(negedge clk);
            lat++;
        end
        en_at_v = mult_enable;
        if (!out_valid) chk("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic recv(input int hold, input logic [31:0] ed, input logic ee, input logic [4:0] erd);
        chk("out_data", out_data, ed);
        chk("out_err", 32'(out_err), 32'(ee));
        chk("out_rd_addr", 32'(out_rd_addr), 32'(erd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data", out_data, ed);
            chk("hold_valid_inready", {30'b0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [4:0]  exp_rd;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int lat;
        bit en_seen, en_at_v, en1;
        logic [11:0] f12;
        logic [31:0] o1, o2, inst, a, b, ed;
        logic ee, legal;
        logic [6:0] f7, opc;
        logic [2:0] f3;
        logic [4:0] rd;

        tbl[0] = '{enc(7'h01, 3'b000, 5'd7),  32'd3,        32'd5,        32'd15,        1'b0, 5'd7};
        tbl[1] = '{enc(7'h01, 3'b001, 5'd9),  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  1'b0, 5'd9};
        tbl[2] = '{enc(7'h01, 3'b011, 5'd10), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0, 5'd10};
        tbl[3] = '{enc(7'h01, 3'b010, 5'd11), 32'h80000000, 32'd2,        32'hFFFFFFFF,  1'b0, 5'd11};
        tbl[4] = '{enc(7'h01, 3'b100, 5'd12), 32'd100,      32'd7,        32'd0,         1'b1, 5'd12};
        tbl[5] = '{enc(7'h00, 3'b000, 5'd13), 32'd4,        32'd4,        32'd0,         1'b1, 5'd13};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_enable", 32'(mult_enable), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_funct3", 32'(mult_funct3), 32'd0);
        chk("rst_rs1_rs2", mult_rs1 | mult_rs2, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rd_addr", 32'(out_rd_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table: legal ops take accept + (stub_lat+1) edges to Done + one edge to register
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].inst, tbl[i].a, tbl[i].b, lat, en_seen, en_at_v, f12, o1, o2, en1);
            chk("tbl_latency", 32'(lat), tbl[i].exp_err ? 32'd1 : 32'(stub_lat + 3));
            chk("tbl_enable_seen", 32'(en_seen), tbl[i].exp_err ? 32'd0 : 32'd1);
            if (!tbl[i].exp_err) begin
                chk("tbl_enable_low_at_valid", 32'(en_at_v), 32'd0);
                chk("tbl_funct12", 32'(f12),
                    32'({tbl[i].inst[30], tbl[i].inst[25], tbl[i].inst[14:12], tbl[i].inst[6:0]}));
                chk("tbl_mult_rs1", o1, tbl[i].a);
                chk("tbl_mult_rs2", o2, tbl[i].b);
            end
            recv(0, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_rd);
        end

        // Repeat of the 3x5 op: cache hit when built in, full MULT run otherwise
        send(tbl[0].inst, 32'd3, 32'd5, lat, en_seen, en_at_v, f12, o1, o2, en1);
`ifdef MULT_CACHE_EN
        chk("cache_hit_latency", 32'(lat), 32'd1);
        chk("cache_hit_no_enable", 32'(en_seen), 32'd0);
`else
        chk("repeat_latency", 32'(lat), 32'(stub_lat + 3));
        chk("repeat_enable_seen", 32'(en_seen), 32'd1);
`endif
        recv(0, 32'd15, 1'b0, 5'd7);
        send(tbl[0].inst, 32'd3, 32'd6, lat, en_seen, en_at_v, f12, o1, o2, en1);
        chk("rs2_change_enable_seen", 32'(en_seen), 32'd1);
        recv(0, 32'd18, 1'b0, 5'd7);

        // Timeout: fill cache with 7x9, hang MULT on another op, then 7x9 must miss
        send(enc(7'h01, 3'b000, 5'd3), 32'd7, 32'd9, lat, en_seen, en_at_v, f12, o1, o2, en1);
        recv(0, 32'd63, 1'b0, 5'd3);
        stub_hang = 1'b1;
        send(enc(7'h01, 3'b011, 5'd20), 32'd11, 32'd13, lat, en_seen, en_at_v, f12, o1, o2, en1);
        chk("timeout_latency", 32'(lat), 32'(TMO + 1));
        chk("timeout_enable_dropped", 32'(en_at_v), 32'd0);
        recv(0, 32'd0, 1'b1, 5'd20);
        stub_hang = 1'b0;
        send(enc(7'h01, 3'b000, 5'd3), 32'd7, 32'd9, lat, en_seen, en_at_v, f12, o1, o2, en1);
        chk("post_timeout_miss", 32'(en_seen), 32'd1);
        recv(0, 32'd63, 1'b0, 5'd3);

        // Writeback backpressure for 10 cycles
        send(enc(7'h01, 3'b000, 5'd21), 32'd1000, 32'd1000, lat, en_seen, en_at_v, f12, o1, o2, en1);
        recv(10, 32'd1000000, 1'b0, 5'd21);

        // Reset while BUSY: no response may follow
        stub_hang = 1'b1;
        wait_idle();
        in_valid = 1'b1; in_inst = enc(7'h01, 3'b000, 5'd4); in_rs1 = 32'd2; in_rs2 = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_enable", 32'(mult_enable), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_enable", 32'(mult_enable), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(out_valid), 32'd0);
        end
        stub_hang = 1'b0;

        // Randomized ops against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            stub_lat = $urandom_range(0, 4);
            f7 = 7'h01; opc = 7'b0110011; f3 = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       f3 = 3'($urandom_range(4, 7));
                    1:       f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
                    default: opc = 7'b0010011;
                endcase
            end
            rd = 5'($urandom);
            inst = {f7, 10'($urandom), f3, rd, opc};
            a = pick_op(); b = pick_op();
            legal = (opc == 7'b0110011) && (f7 == 7'h01) && !f3[2];
            ed = legal ? ref_mult(f3[1:0], a, b) : 32'd0;
            ee = !legal;
            send(inst, a, b, lat, en_seen, en_at_v, f12, o1, o2, en1);
            if (!legal) chk("rnd_illegal_latency", 32'(lat), 32'd1);
`ifndef MULT_CACHE_EN
            if (legal) chk("rnd_latency", 32'(lat), 32'(stub_lat + 3));
`endif
            recv($urandom_range(0, 3), ed, ee, rd);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
